// File: rtl/multicycle_adder.sv
// multicycle_adder: digit-serial adder.
// The operands are captured once and then added DIGIT bits per cycle over
// N = WIDTH/DIGIT cycles, with the carry held in a register between digits.
// A valid/ready handshake on both sides is controlled by an IDLE/RUN/DONE FSM.
// Optional feature: define MULTICYCLE_ADDER_OVF_EN to add the signed-overflow
// output ovf, which is loaded together with sum.
module multicycle_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef MULTICYCLE_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  // Reject configurations that cannot be split into whole digits.
  if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_chk
    $error("multicycle_adder: WIDTH must be a positive multiple of DIGIT");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic             rdy_q, rdy_d;       // low until the first edge after reset
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d; // operands, shifted down one digit per cycle
  logic [WIDTH-1:0] psum_q, psum_d;     // partial sum, filled from the top
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
`ifdef MULTICYCLE_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic [DIGIT-1:0] dig_s;
  logic             dig_c;
  logic [WIDTH-1:0] psum_nx;

  // Current digit is always the low DIGIT bits of the shifted operands.
  assign {dig_c, dig_s} = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                        + (DIGIT+1)'(carry_q);

  // New digit enters at the top; after N cycles digit 0 sits at bit 0.
  assign psum_nx = (psum_q >> DIGIT) | (WIDTH'(dig_s) << (WIDTH - DIGIT));

  // FSM next state, operand capture, digit stepping and result load.
  always_comb begin
    state_d = state_q;
    rdy_d   = 1'b1;
    a_d     = a_q;
    b_d     = b_q;
    psum_d  = psum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef MULTICYCLE_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (rdy_q && in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          psum_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = dig_c;
        psum_d  = psum_nx;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          sum_d   = psum_nx;
          cout_d  = dig_c;
`ifdef MULTICYCLE_ADDER_OVF_EN
          // a^b^s at the MSB recovers the carry into bit WIDTH-1.
          ovf_d   = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dig_s[DIGIT-1] ^ dig_c;
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      psum_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef MULTICYCLE_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      a_q     <= a_d;
      b_q     <= b_d;
      psum_q  <= psum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef MULTICYCLE_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = rdy_q && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef MULTICYCLE_ADDER_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule
